// File: rtl/inst_fetch.sv
// Instruction fetch front-end: holds the PC, issues credit-limited word reads, buffers
// in-order responses for the decoder and drops stale responses after a redirect.

module inst_fetch_chk #(
  parameter int CW = 2
) (
  input logic          iClk,
  input logic          iRst,
  input logic          iMemRvalid,
  input logic [CW-1:0] outstanding
);
  a_no_orphan_resp: assert property (@(posedge iClk) disable iff (!iRst)
    iMemRvalid |-> (outstanding != CW'(0)));
endmodule

module inst_fetch #(
  parameter int                   cXLEN    = 32,
  parameter int                   cPCBitW  = 32,
  parameter logic [cXLEN-1:0]     cResetPc = {cXLEN{1'b0}},
  parameter int                   cDepth   = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  output logic               oMemReq,
  output logic [cXLEN-1:0]   oMemAddr,
  input  logic               iMemGnt,
  input  logic               iMemRvalid,
  input  logic [cPCBitW-1:0] iMemRdata,
  output logic               oValid,
  input  logic               iReady,
  output logic [cPCBitW-1:0] oInst,
  output logic [cXLEN-1:0]   oCurPc,
  input  logic               iRedirect,
  input  logic [cXLEN-1:0]   iRedirectPc
);

  localparam int CW = $clog2(cDepth + 1);
  localparam int PW = (cDepth > 1) ? $clog2(cDepth) : 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(cDepth);
  localparam logic [cXLEN-1:0] PC_STEP = cXLEN'(4);
  localparam logic [1:0] sBoot  = 2'd0;
  localparam logic [1:0] sRun   = 2'd1;
  localparam logic [1:0] sFlush = 2'd2;

  logic [1:0]         state_r, state_s;
  logic [cXLEN-1:0]   pc_r, pc_s, resp_pc_r, resp_pc_s, rpc_s;
  logic [CW-1:0]      outst_r, outst_s, count_r, count_s, drop_r, drop_s;
  logic [PW-1:0]      head_r, head_s, tail_r, tail_s;
  logic               issue_s, resp_s, pop_s, push_s, redirect_s, fwd_s;
  logic [cPCBitW-1:0] mem_inst_r [cDepth];
  logic [cXLEN-1:0]   mem_pc_r   [cDepth];
  logic [cPCBitW-1:0] head_inst_s;
  logic [cXLEN-1:0]   head_pc_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(cDepth - 1)) ? {PW{1'b0}} : p + 1'b1;
  endfunction

  assign rpc_s      = iRedirectPc & ~{{(cXLEN-2){1'b0}}, 2'b11};
  assign issue_s    = oMemReq & iMemGnt;
  assign resp_s     = iMemRvalid & (outst_r != CW'(0));
  assign pop_s      = oValid & iReady;
  assign redirect_s = iRedirect & (state_r != sBoot);
  assign push_s     = resp_s & (state_r == sRun) & ~redirect_s;
  assign outst_s    = outst_r + CW'(issue_s) - CW'(resp_s);
  // The entry pushed this cycle becomes the head when nothing older survives the pop.
  assign fwd_s       = push_s & (tail_r == head_s);
  assign head_inst_s = fwd_s ? iMemRdata : mem_inst_r[head_s];
  assign head_pc_s   = fwd_s ? resp_pc_r : mem_pc_r[head_s];

  // Next-state computation for the fetch FSM, PC, counters and buffer pointers.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    resp_pc_s = resp_pc_r;
    drop_s    = drop_r;
    head_s    = head_r;
    tail_s    = tail_r;
    count_s   = count_r;
    if (redirect_s) begin
      state_s   = (outst_s != CW'(0)) ? sFlush : sRun;
      pc_s      = rpc_s;
      resp_pc_s = rpc_s;
      drop_s    = outst_s;
      count_s   = CW'(0);
      head_s    = {PW{1'b0}};
      tail_s    = {PW{1'b0}};
    end else begin
      head_s  = pop_s ? ptr_inc(head_r) : head_r;
      tail_s  = push_s ? ptr_inc(tail_r) : tail_r;
      count_s = count_r - CW'(pop_s) + CW'(push_s);
      case (state_r)
        sBoot: begin
          state_s   = sRun;
          pc_s      = iRedirect ? rpc_s : pc_r;
          resp_pc_s = iRedirect ? rpc_s : resp_pc_r;
        end
        sRun: begin
          pc_s      = issue_s ? pc_r + PC_STEP : pc_r;
          resp_pc_s = push_s ? resp_pc_r + PC_STEP : resp_pc_r;
        end
        sFlush: begin
          drop_s  = resp_s ? drop_r - CW'(1) : drop_r;
          state_s = (drop_s == CW'(0)) ? sRun : sFlush;
        end
        default: begin
          state_s = sBoot;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_r   <= sBoot;
      pc_r      <= cResetPc;
      resp_pc_r <= cResetPc;
      outst_r   <= CW'(0);
      count_r   <= CW'(0);
      drop_r    <= CW'(0);
      head_r    <= {PW{1'b0}};
      tail_r    <= {PW{1'b0}};
      oMemReq   <= 1'b0;
      oMemAddr  <= {cXLEN{1'b0}};
      oValid    <= 1'b0;
      oInst     <= {cPCBitW{1'b0}};
      oCurPc    <= {cXLEN{1'b0}};
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      resp_pc_r <= resp_pc_s;
      outst_r   <= outst_s;
      count_r   <= count_s;
      drop_r    <= drop_s;
      head_r    <= head_s;
      tail_r    <= tail_s;
      oMemReq   <= (state_s == sRun) &&
                   (({1'b0, outst_s} + {1'b0, count_s}) < {1'b0, DEPTH_C});
      oMemAddr  <= pc_s;
      oValid    <= (count_s != CW'(0)) && (state_s != sBoot);
      if (count_s != CW'(0)) begin
        oInst  <= head_inst_s;
        oCurPc <= head_pc_s;
      end else begin
        oInst  <= oInst;
        oCurPc <= oCurPc;
      end
    end
  end

  // Fetch buffer storage; contents are only meaningful under count_r.
  always_ff @(posedge iClk) begin
    if (push_s) begin
      mem_inst_r[tail_r] <= iMemRdata;
      mem_pc_r[tail_r]   <= resp_pc_r;
    end else begin
      mem_inst_r[tail_r] <= mem_inst_r[tail_r];
      mem_pc_r[tail_r]   <= mem_pc_r[tail_r];
    end
  end

  inst_fetch_chk #(.CW(CW)) u_chk (
    .iClk        (iClk),
    .iRst        (iRst),
    .iMemRvalid  (iMemRvalid),
    .outstanding (outst_r)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model of fetch, memory and decoder,
// compared every cycle, with directed scenarios followed by randomized traffic.

module tb_inst_fetch;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        oMemReq, iMemGnt, iMemRvalid, oValid, iReady, iRedirect;
  logic [31:0] oMemAddr, iMemRdata, oInst, oCurPc, iRedirectPc;

  inst_fetch dut (
    .iClk(iClk), .iRst(iRst), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
    .iMemGnt(iMemGnt), .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata),
    .oValid(oValid), .iReady(iReady), .oInst(oInst), .oCurPc(oCurPc),
    .iRedirect(iRedirect), .iRedirectPc(iRedirectPc)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] pc; bit stale; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  localparam int DEPTH = 2;
  int checks = 0, errors = 0, cyc = 0, lat = 0;
  bit mem_on = 1'b1;
  req_t outq[$];
  ent_t bufq[$];
  ent_t hold;
  bit m_boot;
  logic [31:0] m_pc;
  logic [31:0] issued[$], popped[$];
  bit stall_prev;
  logic [31:0] prev_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    word_of = {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_req();
    m_req = !m_boot && !(outq.size() > 0 && outq[0].stale) &&
            (outq.size() + bufq.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    m_valid = !m_boot && bufq.size() > 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare outputs, drive inputs, advance the model, wait for the next negedge.
  task automatic step(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit rv, issue, pop, push;
    req_t r;
    ent_t e;
    chk("mem_req", 32'(oMemReq), 32'(m_req()));
    if (m_req()) chk("mem_addr", oMemAddr, m_pc);
    chk("valid", 32'(oValid), 32'(m_valid()));
    chk("inst", oInst, hold.inst);
    chk("cur_pc", oCurPc, hold.pc);
    if (stall_prev) chk("addr_stable", oMemAddr, prev_addr);
    if (oMemReq && g) issued.push_back(oMemAddr);
    if (oValid && rdy) popped.push_back(oCurPc);
    rv = mem_on && outq.size() > 0 && outq[0].due <= cyc;
    iMemGnt     = g;
    iReady      = rdy;
    iMemRvalid  = rv;
    iMemRdata   = rv ? word_of(outq[0].pc) : $urandom;
    iRedirect   = rd;
    iRedirectPc = rpc;
    stall_prev  = oMemReq && !g && !rd;
    prev_addr   = oMemAddr;
    issue = m_req() && g;
    pop   = m_valid() && rdy;
    if (m_boot) begin
      m_boot = 1'b0;
      if (rd) m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      push = 1'b0;
      if (rv) begin
        r = outq.pop_front();
        push = !r.stale && !rd;
      end
      if (pop) void'(bufq.pop_front());
      if (push) begin
        e.inst = word_of(r.pc);
        e.pc   = r.pc;
        bufq.push_back(e);
      end
      if (issue) begin
        r.pc = m_pc; r.stale = 1'b0; r.due = cyc + 1 + lat;
        outq.push_back(r);
        m_pc += 32'd4;
      end
      if (rd) begin
        bufq.delete();
        foreach (outq[i]) outq[i].stale = 1'b1;
        m_pc = rpc & 32'hFFFF_FFFC;
      end
    end
    if (bufq.size() > 0) hold = bufq[0];
    cyc++;
    @(negedge iClk);
  endtask

  task automatic do_reset();
    iRst = 1'b0;
    iMemGnt = 1'b0; iReady = 1'b0; iMemRvalid = 1'b0; iRedirect = 1'b0;
    iRedirectPc = 32'd0; iMemRdata = 32'd0;
    #1;
    chk("rst_req_now", 32'(oMemReq), 32'd0);
    chk("rst_valid_now", 32'(oValid), 32'd0);
    outq.delete(); bufq.delete();
    hold.inst = 32'd0; hold.pc = 32'd0;
    m_boot = 1'b1; m_pc = 32'd0; stall_prev = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    chk("rst_addr", oMemAddr, 32'd0);
    chk("rst_inst", oInst, 32'd0);
    chk("rst_cur_pc", oCurPc, 32'd0);
    iRst = 1'b1;
    issued.delete(); popped.delete();
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    qat = (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    bit found;
    @(negedge iClk);

    // Startup with 1-cycle memory and an always-ready decoder.
    do_reset(); lat = 0; mem_on = 1'b1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t1_no_valid_yet", 32'(oValid), 32'd0);
    step(1, 1, 0, 0);
    chk("t1_first_valid", 32'(oValid), 32'd1);
    chk("t1_first_pc", oCurPc, 32'h0);
    chk("t1_first_inst", oInst, 32'h5A5A_F0F0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) chk("t1_issue_addr", qat(issued, i), 32'(4 * i));
    for (int i = 0; i < 4; i++) chk("t1_pop_pc", qat(popped, i), 32'(4 * i));

    // Decoder stalled: credit caps issues at the buffer depth.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("t2_issue_count", 32'(issued.size()), 32'd2);
    chk("t2_req_low", 32'(oMemReq), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("t2_pop0", qat(popped, 0), 32'h0);
    chk("t2_pop1", qat(popped, 1), 32'h4);

    // Redirect with two reads outstanding.
    do_reset(); mem_on = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("t3_outstanding", 32'(issued.size()), 32'd2);
    step(1, 1, 1, 32'h100);
    chk("t3_flush_req", 32'(oMemReq), 32'd0);
    mem_on = 1'b1; popped.delete();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    chk("t3_first_pop", qat(popped, 0), 32'h100);

    // Unaligned redirect landing on a cycle with a response.
    do_reset(); found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outq.size() > 0 && outq[0].due <= cyc) found = 1'b1;
      else step(1, 1, 0, 0);
    end
    chk("t4_resp_cycle", 32'(found), 32'd1);
    step(1, 1, 1, 32'h203);
    issued.delete(); popped.delete();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("t4_first_addr", qat(issued, 0), 32'h200);
    chk("t4_first_pop", qat(popped, 0), 32'h200);

    // Redirect latched in boot near the top of the address space, then wrap.
    do_reset();
    step(1, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("t5_addr_top", qat(issued, 0), 32'hFFFF_FFFC);
    chk("t5_addr_wrap", qat(issued, 1), 32'h0);
    for (int i = 0; i < 12; i++) step(i[0], 1, 0, 0);

    // Reset while the buffer is full.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0, 0);
      found = (bufq.size() == DEPTH);
    end
    chk("t6_buf_full", 32'(found), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    chk("t6_restart_addr", qat(issued, 0), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      lat    = $urandom_range(0, 3);
      mem_on = ($urandom % 4) != 0;
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0,
           (($urandom % 2) == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
